// File: rtl/uart_tx_fifo.sv
// sync_fifo: small generic first-word-fall-through FIFO with a registered full flag.
// Latency: a pushed entry is visible at head_dat one cycle after the push edge.
// Backpressure: push_acc drops when full unless a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic [AW:0]   cnt,
  output logic [AW:0]   cnt_nxt,
  output logic          push_acc,
  output logic          full
);

  localparam int          DEPTH_I = 1 << AW;
  localparam logic [AW:0] DEPTH   = DEPTH_I[AW:0];

  logic [DW-1:0] mem [DEPTH_I];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_acc = push_vld && ((cnt != DEPTH) || pop);
  assign cnt_nxt  = cnt + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop};
  assign head_dat = mem[rd_ptr];

  // Storage array; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge i_wb_clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer, occupancy and full-flag bookkeeping; pointers wrap naturally at depth.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      cnt  <= cnt_nxt;
      full <= (cnt_nxt == DEPTH);
    end
  end

endmodule

// uart_tx_fifo: buffers bridge reply bytes and serialises them as 8N1 frames at CLK_DIV clocks per bit.
// Latency: a byte written at edge N into an idle, empty block drives the start bit after edge N+1.
// Backpressure: none upstream; o_full warns, a write into a full FIFO with no pop is dropped and pulses o_overflow.
module uart_tx_fifo #(
  parameter int CLK_DIV = 104,
  parameter int FIFO_AW = 2
) (
  input  logic       i_wb_clk,
  input  logic       i_wb_rst_n,
  input  logic [7:0] tx_dat,
  input  logic       send,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_full,
  output logic       o_overflow
);

  localparam int          BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [BW-1:0]    baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic [7:0]       head_dat;
  logic [FIFO_AW:0] fifo_cnt;
  logic [FIFO_AW:0] fifo_cnt_nxt;
  logic             push_acc;
  logic             fifo_nempty;
  logic             bit_end;
  logic             pop;

  assign bit_end     = (baud_cnt == '0);
  assign fifo_nempty = (fifo_cnt != '0);
  // The head leaves either from IDLE or exactly as a stop bit ends, so frames butt together.
  assign pop         = fifo_nempty && ((state == IDLE) || ((state == STOP) && bit_end));

  sync_fifo #(
    .DW (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .i_wb_clk   (i_wb_clk),
    .i_wb_rst_n (i_wb_rst_n),
    .push_vld   (send),
    .push_dat   (tx_dat),
    .pop        (pop),
    .head_dat   (head_dat),
    .cnt        (fifo_cnt),
    .cnt_nxt    (fifo_cnt_nxt),
    .push_acc   (push_acc),
    .full       (o_full)
  );

  // Dropped writes are flagged for exactly the cycle after the rejected strobe.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= send && !push_acc;
    end
  end

  // Frame sequencer: each bit holds o_tx for CLK_DIV clocks, reloading the baud counter at every bit start.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= head_dat;
            baud_cnt <= BAUD_LOAD;
            o_tx     <= 1'b0;
            o_busy   <= 1'b1;
            state    <= START;
          end else begin
            o_busy   <= (fifo_cnt_nxt != '0);
          end
        end
        START: begin
          o_busy <= 1'b1;
          if (bit_end) begin
            bit_idx  <= '0;
            baud_cnt <= BAUD_LOAD;
            o_tx     <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        DATA: begin
          o_busy <= 1'b1;
          if (bit_end) begin
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            baud_cnt <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              // The next data bit is the one about to reach shift[0].
              o_tx  <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift    <= head_dat;
              baud_cnt <= BAUD_LOAD;
              o_tx     <= 1'b0;
              o_busy   <= 1'b1;
              state    <= START;
            end else begin
              o_busy   <= (fifo_cnt_nxt != '0);
              state    <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
            o_busy   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int CD0 = 4;
  localparam int CD1 = 8;
  localparam int CD2 = 5;

  logic       i_wb_clk   = 1'b0;
  logic       i_wb_rst_n = 1'b0;
  logic [2:0] send_v     = '0;
  logic [7:0] dat0       = '0;
  logic [7:0] dat1       = '0;
  logic [7:0] dat2       = '0;
  logic [2:0] tx_v;
  logic [2:0] busy_v;
  logic [2:0] full_v;
  logic [2:0] ovf_v;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];

  always #5 i_wb_clk = ~i_wb_clk;

  uart_tx_fifo #(.CLK_DIV(CD0), .FIFO_AW(2)) u0 (
    .i_wb_clk(i_wb_clk), .i_wb_rst_n(i_wb_rst_n), .tx_dat(dat0), .send(send_v[0]),
    .o_tx(tx_v[0]), .o_busy(busy_v[0]), .o_full(full_v[0]), .o_overflow(ovf_v[0]));

  uart_tx_fifo #(.CLK_DIV(CD1), .FIFO_AW(2)) u1 (
    .i_wb_clk(i_wb_clk), .i_wb_rst_n(i_wb_rst_n), .tx_dat(dat1), .send(send_v[1]),
    .o_tx(tx_v[1]), .o_busy(busy_v[1]), .o_full(full_v[1]), .o_overflow(ovf_v[1]));

  uart_tx_fifo #(.CLK_DIV(CD2), .FIFO_AW(2)) u2 (
    .i_wb_clk(i_wb_clk), .i_wb_rst_n(i_wb_rst_n), .tx_dat(dat2), .send(send_v[2]),
    .o_tx(tx_v[2]), .o_busy(busy_v[2]), .o_full(full_v[2]), .o_overflow(ovf_v[2]));

  task automatic tick();
    @(posedge i_wb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Level of bit k (0=start, 1..8=data LSB first, 9=stop) of an 8N1 frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // Line level s clocks after the first start bit, for the bytes of exp_q sent back to back.
  function automatic logic line_model(input int s, input int cd);
    int f;
    f = s / (10 * cd);
    if (f >= exp_q.size()) return 1'b1;
    return frame_bit(exp_q[f], (s / cd) % 10);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b [6];
    logic [7:0] r;
    int         g_s;
    int         g_r;

    // Reset state of every instance.
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_tx",   8'(tx_v[i]),   8'd1);
      chk("rst_busy", 8'(busy_v[i]), 8'd0);
      chk("rst_full", 8'(full_v[i]), 8'd0);
      chk("rst_ovf",  8'(ovf_v[i]),  8'd0);
    end
    i_wb_rst_n = 1'b1;
    tick();

    // Single byte 0xA5 at CLK_DIV=4.
    dat0 = 8'hA5; send_v[0] = 1'b1;
    tick();
    send_v[0] = 1'b0;
    chk("t1_tx_before_fall", 8'(tx_v[0]),   8'd1);
    chk("t1_busy_on_accept", 8'(busy_v[0]), 8'd1);
    tick();
    exp_q = '{8'hA5};
    for (int s = 0; s < 40; s++) begin
      chk("t1_tx",   8'(tx_v[0]),   8'(line_model(s, CD0)));
      chk("t1_busy", 8'(busy_v[0]), 8'd1);
      tick();
    end
    chk("t1_tx_idle",   8'(tx_v[0]),   8'd1);
    chk("t1_busy_done", 8'(busy_v[0]), 8'd0);
    chk("t1_ovf",       8'(ovf_v[0]),  8'd0);

    // Bridge reply "3F": 0x33 then 0x46 two cycles apart at CLK_DIV=8.
    dat1 = 8'h33; send_v[1] = 1'b1;
    tick();
    send_v[1] = 1'b0;
    tick();
    exp_q = '{8'h33, 8'h46};
    for (int s = 0; s < 160; s++) begin
      chk("t2_tx",  8'(tx_v[1]),  8'(line_model(s, CD1)));
      chk("t2_ovf", 8'(ovf_v[1]), 8'd0);
      if (s == 0) begin dat1 = 8'h46; send_v[1] = 1'b1; end
      if (s == 1) send_v[1] = 1'b0;
      tick();
    end
    chk("t2_busy_done", 8'(busy_v[1]), 8'd0);

    // Five consecutive sends fill the FIFO; a sixth is dropped.
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      dat0 = b[k]; send_v[0] = 1'b1;
      tick();
      if (k == 4) chk("t3_full_after_5", 8'(full_v[0]), 8'd1);
      if (k == 5) chk("t3_ovf_pulse",    8'(ovf_v[0]),  8'd1);
    end
    send_v[0] = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 5; k++) exp_q.push_back(b[k]);
    for (int s = 4; s < 200; s++) begin
      chk("t3_tx", 8'(tx_v[0]), 8'(line_model(s, CD0)));
      if (s >= 5) chk("t3_ovf_once", 8'(ovf_v[0]), 8'd0);
      chk("t3_full", 8'(full_v[0]), 8'(s < 40));
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      chk("t3_dropped_not_sent", 8'(tx_v[0]),   8'd1);
      chk("t3_busy_done",        8'(busy_v[0]), 8'd0);
      tick();
    end

    // Write while full exactly as the first stop bit ends: accepted, no overflow.
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    for (int k = 0; k < 5; k++) begin
      dat0 = b[k]; send_v[0] = 1'b1;
      tick();
    end
    send_v[0] = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 6; k++) exp_q.push_back(b[k]);
    for (int s = 3; s < 240; s++) begin
      chk("t4_tx",   8'(tx_v[0]),   8'(line_model(s, CD0)));
      chk("t4_ovf",  8'(ovf_v[0]),  8'd0);
      chk("t4_full", 8'(full_v[0]), 8'(s < 80));
      if (s == 39) begin dat0 = b[5]; send_v[0] = 1'b1; end
      if (s == 40) send_v[0] = 1'b0;
      tick();
    end
    chk("t4_busy_done", 8'(busy_v[0]), 8'd0);

    // Reset during data bit 3 (forced low) with two bytes still queued.
    for (int k = 0; k < 3; k++) b[k] = 8'($urandom);
    b[0] = b[0] & 8'hF7;
    exp_q.delete();
    exp_q.push_back(b[0]);
    for (int k = 0; k < 3; k++) begin
      dat0 = b[k]; send_v[0] = 1'b1;
      tick();
    end
    send_v[0] = 1'b0;
    repeat (16) tick();
    chk("t5_bit3_low", 8'(tx_v[0]),   8'(line_model(17, CD0)));
    chk("t5_busy_pre", 8'(busy_v[0]), 8'd1);
    #1 i_wb_rst_n = 1'b0;
    #1;
    chk("t5_tx_immediate", 8'(tx_v[0]),   8'd1);
    chk("t5_busy_reset",   8'(busy_v[0]), 8'd0);
    chk("t5_full_reset",   8'(full_v[0]), 8'd0);
    tick();
    tick();
    i_wb_rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("t5_tx_quiet",   8'(tx_v[0]),   8'd1);
      chk("t5_busy_quiet", 8'(busy_v[0]), 8'd0);
    end

    // 16 random bytes through a receiver model at CLK_DIV=5.
    sent_q.delete();
    rx_q.delete();
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          repeat ($urandom_range(0, 25)) tick();
          g_s = 0;
          while (full_v[2] && g_s < 500) begin tick(); g_s++; end
          chk("t6_room", 8'(full_v[2]), 8'd0);
          dat2 = 8'($urandom); send_v[2] = 1'b1;
          sent_q.push_back(dat2);
          tick();
          send_v[2] = 1'b0;
          chk("t6_ovf", 8'(ovf_v[2]), 8'd0);
        end
      end
      begin
        for (int k = 0; k < 16; k++) begin
          g_r = 0;
          while (tx_v[2] === 1'b1 && g_r < 4000) begin tick(); g_r++; end
          chk("t6_start_edge", 8'(tx_v[2]), 8'd0);
          if (tx_v[2] !== 1'b0) break;
          repeat (2) tick();
          chk("t6_start_mid", 8'(tx_v[2]), 8'd0);
          for (int i = 0; i < 8; i++) begin
            repeat (CD2) tick();
            r[i] = tx_v[2];
          end
          repeat (CD2) tick();
          chk("t6_stop_mid", 8'(tx_v[2]), 8'd1);
          rx_q.push_back(r);
        end
      end
    join
    chk("t6_rx_count", 8'(rx_q.size()), 8'd16);
    for (int i = 0; i < rx_q.size(); i++) begin
      chk("t6_rx_byte", rx_q[i], sent_q[i]);
    end
    repeat (20) tick();
    chk("t6_busy_done", 8'(busy_v[2]), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
